ps2_scancode_decoder: RTL and testbench

Consumes raw PS/2 set-2 scan-code bytes from the PS/2 keyboard receiver FIFO and turns them into complete key events (make/break, extended flag, scan code, ASCII), with shift and caps-lock tracking. It sits directly downstream of the receiver: it pops bytes with the receiver's active-low `nextdata_n` strobe and presents one event at a time to the CPU-side consumer over a valid/ready handshake.

---
 rtl/ps2_scancode_decoder.sv | 166 ++++++++++++++++
 tb/tb_ps2_scancode_decoder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scan-code decoder: pops receiver FIFO bytes and emits key events with shift/caps tracking.
// Optional typematic-repeat filter enabled by defining PS2_DEC_TYPEMATIC_FILTER_EN.
module ps2_scancode_decoder (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] kbd_data,
  input  logic       kbd_ready,
  output logic       kbd_nextdata_n,
  output logic       key_valid,
  input  logic       key_ready,
  output logic [7:0] key_code,
  output logic       key_break,
  output logic       key_ext,
  output logic [7:0] key_ascii,
  output logic       shift,
  output logic       caps
);

  localparam int unsigned CODE_W = 8;

  typedef enum logic [1:0] {IDLE, ACK, DECODE, EMIT} state_t;

  state_t state, next_state;

  logic [CODE_W-1:0] byte_r;
  logic              ext_r, brk_r, lsh_r, rsh_r;

  logic              is_e0, is_f0, is_shift_key, is_caps_key, drop_c;
  logic              lsh_d, rsh_d, caps_d, shift_d, nextdata_n_d, valid_d;
  logic [CODE_W-1:0] ascii_d;

`ifdef PS2_DEC_TYPEMATIC_FILTER_EN
  logic [CODE_W:0]   last_r;
  logic              last_vld_r;
`endif

  // Set-2 code to ASCII; letters flip case on shift^caps, digits only follow shift.
  function automatic logic [7:0] to_ascii(input logic [7:0] code, input logic sh, input logic cp);
    logic [7:0] letter;
    logic [7:0] res;
    letter = 8'h00;
    res    = 8'h00;
    case (code)
      8'h1C: letter = 8'h61; 8'h32: letter = 8'h62; 8'h21: letter = 8'h63; 8'h23: letter = 8'h64;
      8'h24: letter = 8'h65; 8'h2B: letter = 8'h66; 8'h34: letter = 8'h67; 8'h33: letter = 8'h68;
      8'h43: letter = 8'h69; 8'h3B: letter = 8'h6A; 8'h42: letter = 8'h6B; 8'h4B: letter = 8'h6C;
      8'h3A: letter = 8'h6D; 8'h31: letter = 8'h6E; 8'h44: letter = 8'h6F; 8'h4D: letter = 8'h70;
      8'h15: letter = 8'h71; 8'h2D: letter = 8'h72; 8'h1B: letter = 8'h73; 8'h2C: letter = 8'h74;
      8'h3C: letter = 8'h75; 8'h2A: letter = 8'h76; 8'h1D: letter = 8'h77; 8'h22: letter = 8'h78;
      8'h35: letter = 8'h79; 8'h1A: letter = 8'h7A;
      default: letter = 8'h00;
    endcase
    case (code)
      8'h45: res = sh ? 8'h29 : 8'h30;
      8'h16: res = sh ? 8'h21 : 8'h31;
      8'h1E: res = sh ? 8'h40 : 8'h32;
      8'h26: res = sh ? 8'h23 : 8'h33;
      8'h25: res = sh ? 8'h24 : 8'h34;
      8'h2E: res = sh ? 8'h25 : 8'h35;
      8'h36: res = sh ? 8'h5E : 8'h36;
      8'h3D: res = sh ? 8'h26 : 8'h37;
      8'h3E: res = sh ? 8'h2A : 8'h38;
      8'h46: res = sh ? 8'h28 : 8'h39;
      8'h29: res = 8'h20;
      8'h5A: res = 8'h0D;
      8'h66: res = 8'h08;
      8'h0D: res = 8'h09;
      8'h76: res = 8'h1B;
      default: res = (letter != 8'h00 && (sh ^ cp)) ? letter - 8'h20 : letter;
    endcase
    return res;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (kbd_ready) next_state = ACK;
      ACK:     next_state = DECODE;
      DECODE:  next_state = (is_e0 || is_f0 || drop_c) ? IDLE : EMIT;
      EMIT:    if (key_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    is_e0        = (byte_r == 8'hE0);
    is_f0        = (byte_r == 8'hF0);
    is_shift_key = !ext_r && (byte_r == 8'h12 || byte_r == 8'h59);
    is_caps_key  = !ext_r && (byte_r == 8'h58);
`ifdef PS2_DEC_TYPEMATIC_FILTER_EN
    drop_c       = !brk_r && !is_shift_key && last_vld_r && (last_r == {ext_r, byte_r});
`else
    drop_c       = 1'b0;
`endif
    lsh_d        = (!ext_r && byte_r == 8'h12) ? !brk_r : lsh_r;
    rsh_d        = (!ext_r && byte_r == 8'h59) ? !brk_r : rsh_r;
    caps_d       = (is_caps_key && !brk_r && !drop_c) ? !caps : caps;
    shift_d      = lsh_d | rsh_d;
    ascii_d      = (brk_r || ext_r) ? 8'h00 : to_ascii(byte_r, shift_d, caps_d);
    nextdata_n_d = (next_state != ACK);
    valid_d      = (next_state == EMIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_r         <= '0;
      ext_r          <= 1'b0;
      brk_r          <= 1'b0;
      lsh_r          <= 1'b0;
      rsh_r          <= 1'b0;
      kbd_nextdata_n <= 1'b1;
      key_valid      <= 1'b0;
      key_code       <= '0;
      key_break      <= 1'b0;
      key_ext        <= 1'b0;
      key_ascii      <= '0;
      shift          <= 1'b0;
      caps           <= 1'b0;
`ifdef PS2_DEC_TYPEMATIC_FILTER_EN
      last_r         <= '0;
      last_vld_r     <= 1'b0;
`endif
    end else begin
      kbd_nextdata_n <= nextdata_n_d;
      key_valid      <= valid_d;
      if (state == IDLE && kbd_ready) byte_r <= kbd_data;
      if (state == DECODE) begin
        if (is_e0) begin
          ext_r <= 1'b1;
        end else if (is_f0) begin
          brk_r <= 1'b1;
        end else begin
          ext_r <= 1'b0;
          brk_r <= 1'b0;
          lsh_r <= lsh_d;
          rsh_r <= rsh_d;
          shift <= shift_d;
          caps  <= caps_d;
          if (!drop_c) begin
            key_code  <= byte_r;
            key_break <= brk_r;
            key_ext   <= ext_r;
            key_ascii <= ascii_d;
          end
`ifdef PS2_DEC_TYPEMATIC_FILTER_EN
          // Track the last held non-shift key so auto-repeat makes can be dropped.
          if (!is_shift_key) begin
            if (!brk_r) begin
              last_r     <= {ext_r, byte_r};
              last_vld_r <= 1'b1;
            end else if (last_r == {ext_r, byte_r}) begin
              last_vld_r <= 1'b0;
            end
          end
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder: FIFO model feeds bytes, a scoreboard queue checks emitted events.
module tb_ps2_scancode_decoder;

  typedef struct packed {
    logic [7:0] code;
    logic       brk;
    logic       ext;
    logic [7:0] ascii;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] kbd_data;
  logic       kbd_ready;
  logic       kbd_nextdata_n;
  logic       key_valid;
  logic       key_ready;
  logic [7:0] key_code;
  logic       key_break;
  logic       key_ext;
  logic [7:0] key_ascii;
  logic       shift;
  logic       caps;

  logic [7:0] fifo[$];
  ev_t        expq[$];
  int         tests  = 0;
  int         fails  = 0;
  int         pops   = 0;
  int         events = 0;

  ps2_scancode_decoder dut (
    .clk(clk), .rst(rst), .kbd_data(kbd_data), .kbd_ready(kbd_ready),
    .kbd_nextdata_n(kbd_nextdata_n), .key_valid(key_valid), .key_ready(key_ready),
    .key_code(key_code), .key_break(key_break), .key_ext(key_ext),
    .key_ascii(key_ascii), .shift(shift), .caps(caps)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
  endtask

  task automatic expect_ev(input logic [7:0] code, input logic brk, input logic ext, input logic [7:0] ascii);
    ev_t e;
    e.code = code; e.brk = brk; e.ext = ext; e.ascii = ascii;
    expq.push_back(e);
  endtask

  task automatic drain(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      @(posedge clk);
      if (fifo.size() == 0 && expq.size() == 0 && !key_valid) done = 1'b1;
    end
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_drain"}, 32'(done), 32'd1);
  endtask

  // Receiver FIFO model: pop on the low strobe, then refresh head/non-empty.
  always @(negedge clk) begin
    if (!rst && !kbd_nextdata_n) begin
      if (fifo.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL pop_when_empty: got pop expected none");
      end else begin
        void'(fifo.pop_front());
        pops++;
      end
    end
    kbd_ready = (fifo.size() > 0);
    kbd_data  = (fifo.size() > 0) ? fifo[0] : 8'h00;
  end

  // Event monitor: stability while held, scoreboard compare on acceptance.
  ev_t obs, prev;
  bit  held = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else if (key_valid) begin
      obs = {key_code, key_break, key_ext, key_ascii};
      if (held) chk("event_stable", 32'(obs), 32'(prev));
      if (key_ready) begin
        events++;
        held = 1'b0;
        if (expq.size() == 0) begin
          tests++;
          fails++;
          $error("FAIL unexpected_event: got %0h expected none", obs);
        end else begin
          chk("event", 32'(obs), 32'(expq.pop_front()));
        end
      end else begin
        held = 1'b1;
        prev = obs;
      end
    end else if (held) begin
      held = 1'b0;
      chk("valid_dropped", 32'(key_valid), 32'd1);
    end
  end

  int p0, e0;

  initial begin
    rst       = 1'b1;
    key_ready = 1'b1;
    kbd_ready = 1'b0;
    kbd_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_nextdata_n", 32'(kbd_nextdata_n), 32'd1);
    chk("rst_valid", 32'(key_valid), 32'd0);
    chk("rst_fields", 32'({key_code, key_break, key_ext, key_ascii}), 32'd0);
    chk("rst_mods", 32'({shift, caps}), 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Single key with first-event latency
    p0 = pops;
    push(8'h1C);
    expect_ev(8'h1C, 1'b0, 1'b0, 8'h61);
    @(posedge clk); @(posedge clk); #1;
    chk("latency_early", 32'(key_valid), 32'd0);
    @(posedge clk); #1;
    chk("latency_valid", 32'(key_valid), 32'd1);
    push(8'hF0); push(8'h1C);
    expect_ev(8'h1C, 1'b1, 1'b0, 8'h00);
    drain("single");
    chk("single_pops", 32'(pops - p0), 32'd3);

    // Shift and caps lock
    push(8'h12); expect_ev(8'h12, 1'b0, 1'b0, 8'h00);
    push(8'h1C); expect_ev(8'h1C, 1'b0, 1'b0, 8'h41);
    push(8'hF0); push(8'h1C); expect_ev(8'h1C, 1'b1, 1'b0, 8'h00);
    push(8'hF0); push(8'h12); expect_ev(8'h12, 1'b1, 1'b0, 8'h00);
    push(8'h58); expect_ev(8'h58, 1'b0, 1'b0, 8'h00);
    push(8'hF0); push(8'h58); expect_ev(8'h58, 1'b1, 1'b0, 8'h00);
    push(8'h1C); expect_ev(8'h1C, 1'b0, 1'b0, 8'h41);
    push(8'hF0); push(8'h1C); expect_ev(8'h1C, 1'b1, 1'b0, 8'h00);
    drain("caps_on");
    chk("caps_on", 32'({shift, caps}), 32'b01);
    push(8'h12); expect_ev(8'h12, 1'b0, 1'b0, 8'h00);
    push(8'h1C); expect_ev(8'h1C, 1'b0, 1'b0, 8'h61);
    push(8'hF0); push(8'h1C); expect_ev(8'h1C, 1'b1, 1'b0, 8'h00);
    push(8'h16); expect_ev(8'h16, 1'b0, 1'b0, 8'h21);
    drain("shift_caps");
    chk("shift_caps", 32'({shift, caps}), 32'b11);
    push(8'hF0); push(8'h16); expect_ev(8'h16, 1'b1, 1'b0, 8'h00);
    push(8'hF0); push(8'h12); expect_ev(8'h12, 1'b1, 1'b0, 8'h00);
    push(8'h58); expect_ev(8'h58, 1'b0, 1'b0, 8'h00);
    push(8'hF0); push(8'h58); expect_ev(8'h58, 1'b1, 1'b0, 8'h00);
    push(8'h45); expect_ev(8'h45, 1'b0, 1'b0, 8'h30);
    push(8'hF0); push(8'h45); expect_ev(8'h45, 1'b1, 1'b0, 8'h00);
    drain("mods_off");
    chk("mods_off", 32'({shift, caps}), 32'b00);

    // Extended keys and fake shift
    push(8'hE0); push(8'h75); expect_ev(8'h75, 1'b0, 1'b1, 8'h00);
    push(8'hE0); push(8'hF0); push(8'h75); expect_ev(8'h75, 1'b1, 1'b1, 8'h00);
    push(8'hE0); push(8'h12); expect_ev(8'h12, 1'b0, 1'b1, 8'h00);
    drain("fake_shift");
    chk("fake_shift", 32'(shift), 32'd0);
    push(8'hE0); push(8'hF0); push(8'h12); expect_ev(8'h12, 1'b1, 1'b1, 8'h00);
    push(8'hF0); push(8'hF0); push(8'h29); expect_ev(8'h29, 1'b1, 1'b0, 8'h00);
    push(8'h5A); expect_ev(8'h5A, 1'b0, 1'b0, 8'h0D);
    push(8'hF0); push(8'h5A); expect_ev(8'h5A, 1'b1, 1'b0, 8'h00);
    drain("ext");

    // Backpressure holds the event and stops popping
    key_ready = 1'b0;
    p0 = pops;
    push(8'h1C); push(8'h32);
    expect_ev(8'h1C, 1'b0, 1'b0, 8'h61);
    expect_ev(8'h32, 1'b0, 1'b0, 8'h62);
    repeat (20) @(posedge clk);
    #1;
    chk("bp_valid", 32'(key_valid), 32'd1);
    chk("bp_code", 32'(key_code), 32'h1C);
    chk("bp_pops", 32'(pops - p0), 32'd1);
    chk("bp_fifo", 32'(fifo.size()), 32'd1);
    key_ready = 1'b1;
    push(8'hF0); push(8'h1C); expect_ev(8'h1C, 1'b1, 1'b0, 8'h00);
    push(8'hF0); push(8'h32); expect_ev(8'h32, 1'b1, 1'b0, 8'h00);
    drain("backpressure");

    // Typematic repeats
    e0 = events;
    push(8'h1C); push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C);
    expect_ev(8'h1C, 1'b0, 1'b0, 8'h61);
`ifndef PS2_DEC_TYPEMATIC_FILTER_EN
    expect_ev(8'h1C, 1'b0, 1'b0, 8'h61);
    expect_ev(8'h1C, 1'b0, 1'b0, 8'h61);
`endif
    expect_ev(8'h1C, 1'b1, 1'b0, 8'h00);
    drain("typematic");
`ifdef PS2_DEC_TYPEMATIC_FILTER_EN
    chk("typematic_events", 32'(events - e0), 32'd2);
`else
    chk("typematic_events", 32'(events - e0), 32'd4);
`endif

    // Reset while a break prefix is pending
    push(8'h12); expect_ev(8'h12, 1'b0, 1'b0, 8'h00);
    push(8'h58); expect_ev(8'h58, 1'b0, 1'b0, 8'h00);
    push(8'hF0); push(8'h58); expect_ev(8'h58, 1'b1, 1'b0, 8'h00);
    drain("pre_reset");
    chk("pre_reset_mods", 32'({shift, caps}), 32'b11);
    push(8'hF0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_nextdata_n", 32'(kbd_nextdata_n), 32'd1);
    chk("mid_rst_valid", 32'(key_valid), 32'd0);
    chk("mid_rst_fields", 32'({key_code, key_break, key_ext, key_ascii}), 32'd0);
    chk("mid_rst_mods", 32'({shift, caps}), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    push(8'h1C); expect_ev(8'h1C, 1'b0, 1'b0, 8'h61);
    drain("post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
